game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Game-flow controller for the Pac-Man top level. It sequences attract, ready, play, death, win and game-over phases, and owns the lives counter. It gates the pacman/ghost movement engines, requests position and score re-initialisation, and supplies phase and blink information to color_mapper for banners. Movement timing is derived from the VGA vsync, which is edge-detected internally in the Clk domain.

Parameters:
START_LIVES, 3, lives loaded on new game (1..3)
READY_FRAMES, 120, frames spent in READY before play starts
DEATH_FRAMES, 90, frames spent in DYING animation
END_FRAMES, 180, frames in WIN/GAMEOVER before start key is accepted
START_KEY, 8'h2C, USB HID keycode that starts a game (space)
BLINK_SHIFT, 4, blink toggles every 2^BLINK_SHIFT frames

Ports:
Clk  in  1  system clock (100 MHz)
Reset  in  1  synchronous, active-high reset
vsync  in  1  VGA vsync level (pixel-clock domain, quasi-static vs Clk)
keycode  in  8  keycode0_gpio[7:0]
collide  in  1  any ghost within collision radius (level)
all_eaten  in  1  score reached win value (level)
game_state  out  3  0 IDLE, 1 READY, 2 PLAY, 3 DYING, 4 WIN, 5 GAMEOVER
run_en  out  1  movement enable for ball/ghost modules
pos_reset  out  1  1-cycle pulse: return actors to start positions
score_clear  out  1  1-cycle pulse: clear score and pellet map
lives  out  2  remaining lives
blink  out  1  banner blink phase
frame_stb  out  1  1-cycle pulse per frame (exported for reuse)

Behaviour:
- Reset: game_state=IDLE, lives=0, run_en=0, pos_reset=0, score_clear=0, blink=0, frame_cnt=0, frame_stb=0; the vsync synchroniser (2 flops) is reset to 1.
- Frame strobe: 2-flop synchroniser on vsync, then falling-edge detect (vsync is active-low). frame_stb is high for exactly one Clk cycle per vsync pulse, with a latency of 3 Clk cycles from the vsync edge.
- frame_cnt: 8-bit down-counter. It is loaded on every state entry and decrements on frame_stb, saturating at 0. "Expired" means frame_cnt==0 and frame_stb is high.
- blink_cnt: free-running counter on frame_stb. blink = blink_cnt[BLINK_SHIFT]. It is cleared on every state entry.
- IDLE: if keycode==START_KEY, then lives<=START_LIVES and score_clear and pos_reset pulse; go to READY with frame_cnt=READY_FRAMES-1.
- READY: when expired, go to PLAY. Keys are ignored.
- PLAY: run_en=1 (combinational on state).
  - If collide, go to DYING with frame_cnt=DEATH_FRAMES-1.
  - Else if all_eaten, go to WIN with frame_cnt=END_FRAMES-1.
  - collide has priority when both are high in the same cycle.
  - Inputs are sampled every Clk, not only on frame_stb.
- DYING: when expired, lives decrements.
  - If the pre-decrement lives==1, go to GAMEOVER (lives=0) with frame_cnt=END_FRAMES-1.
  - Otherwise pulse pos_reset and go to READY; score is kept.
- WIN / GAMEOVER: keys are ignored until expired, then hold. After expiry, keycode==START_KEY behaves as in IDLE (new game: score_clear, pos_reset, lives reload, READY).
  - A key already held at expiry starts a game on the first cycle it is sampled. No release is required.
- run_en=0 in all states except PLAY. pos_reset and score_clear are never high for more than one cycle and are registered outputs.
- lives never wraps below 0. A decrement at 0 is impossible by construction; an assertion covers it.
- Reset asserted in any state returns to the reset values on the next Clk edge; any in-flight pulse is dropped.
- vsync stuck (no edges): timed states hold indefinitely, with no spurious strobes.
- Undefined state encodings 6 and 7 recover to IDLE on the next cycle.

Test Plan:
- Reset, then drive keycode=8'h2C for 1 cycle → next cycle: game_state=1, lives=3, score_clear=1 and pos_reset=1 each for exactly 1 cycle.
- READY_FRAMES=4, vsync at 40-cycle period → game_state=2 after the 4th frame_stb, with run_en rising the same cycle; frame_stb spacing is 40 cycles.
- PLAY, pulse collide=1 for 1 cycle → DYING, run_en=0. After DEATH_FRAMES strobes: lives=2, pos_reset pulse, state=READY.
- PLAY with lives=1, collide → after death frames: game_state=5, lives=0. Key 8'h2C held during END_FRAMES has no effect; after expiry, state=READY with lives=3.
- PLAY, collide=1 and all_eaten=1 in the same cycle → game_state=3, not 4.
- Reset asserted mid-DYING while a pos_reset would fire → next cycle: state=0, lives=0, no pos_reset pulse. Stopping vsync in READY leaves the state held for 1000 cycles.

Source files
------------

// File: rtl/game_sequencer.sv
// Game-flow controller: sequences attract/ready/play/death/win/game-over phases,
// owns the lives counter and derives a per-frame strobe from the VGA vsync.
module game_sequencer #(
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned READY_FRAMES = 120,
    parameter int unsigned DEATH_FRAMES = 90,
    parameter int unsigned END_FRAMES   = 180,
    parameter logic [7:0]  START_KEY    = 8'h2C,
    parameter int unsigned BLINK_SHIFT  = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vsync,
    input  logic [7:0] keycode,
    input  logic       collide,
    input  logic       all_eaten,
    output logic [2:0] game_state,
    output logic       run_en,
    output logic       pos_reset,
    output logic       score_clear,
    output logic [1:0] lives,
    output logic       blink,
    output logic       frame_stb
);
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BLINK_W = BLINK_SHIFT + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READY    = 3'd1,
        S_PLAY     = 3'd2,
        S_DYING    = 3'd3,
        S_WIN      = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               vs_s1;
    logic               vs_s2;
    logic               vs_d;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   frame_load;
    logic [BLINK_W-1:0] blink_cnt;
    logic               end_done;
    logic               expired;
    logic               start_key;
    logic               enter;
    logic               start_game_c;
    logic               death_retry_c;
    logic               lives_dec_c;

    assign start_key  = (keycode == START_KEY);
    assign expired    = (frame_cnt == '0) && frame_stb;
    assign enter      = (state_nxt != state);
    assign game_state = state;
    assign run_en     = (state == S_PLAY);
    assign blink      = blink_cnt[BLINK_SHIFT];

    // vsync is active-low: synchronise, then strobe on the falling edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_s1     <= 1'b1;
            vs_s2     <= 1'b1;
            vs_d      <= 1'b1;
            frame_stb <= 1'b0;
        end else begin
            vs_s1     <= vsync;
            vs_s2     <= vs_s1;
            vs_d      <= vs_s2;
            frame_stb <= vs_d & ~vs_s2;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_key) state_nxt = S_READY;
            end
            S_READY: begin
                if (expired) state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (collide)        state_nxt = S_DYING;
                else if (all_eaten) state_nxt = S_WIN;
            end
            S_DYING: begin
                if (expired) state_nxt = (lives == 2'd1) ? S_GAMEOVER : S_READY;
            end
            S_WIN, S_GAMEOVER: begin
                if (end_done && start_key) state_nxt = S_READY;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_game_c  = 1'b0;
        death_retry_c = 1'b0;
        lives_dec_c   = 1'b0;
        frame_load    = '0;
        case (state)
            S_IDLE: start_game_c = start_key;
            S_DYING: begin
                lives_dec_c   = expired;
                death_retry_c = expired && (lives != 2'd1);
            end
            S_WIN, S_GAMEOVER: start_game_c = end_done && start_key;
            default: ;
        endcase
        case (state_nxt)
            S_READY:           frame_load = CNT_W'(READY_FRAMES - 1);
            S_DYING:           frame_load = CNT_W'(DEATH_FRAMES - 1);
            S_WIN, S_GAMEOVER: frame_load = CNT_W'(END_FRAMES - 1);
            default:           frame_load = '0;
        endcase
    end

    // Phase timers restart on every state entry; end_done latches WIN/GAMEOVER expiry
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt   <= '0;
            blink_cnt   <= '0;
            end_done    <= 1'b0;
            lives       <= 2'd0;
            pos_reset   <= 1'b0;
            score_clear <= 1'b0;
        end else begin
            pos_reset   <= start_game_c | death_retry_c;
            score_clear <= start_game_c;
            if (start_game_c) begin
                lives <= 2'(START_LIVES);
            end else if (lives_dec_c) begin
                lives <= lives - 2'd1;
            end
            if (enter) begin
                frame_cnt <= frame_load;
                blink_cnt <= '0;
                end_done  <= 1'b0;
            end else begin
                if (frame_stb) begin
                    if (frame_cnt != '0) frame_cnt <= frame_cnt - CNT_W'(1);
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
                if (((state == S_WIN) || (state == S_GAMEOVER)) && expired) end_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && lives_dec_c) begin
            assert (lives != 2'd0);
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised and directed bench for game_sequencer, checked every cycle against
// a phase/frame-count model of the game flow.
module tb_game_sequencer;
    localparam int START_LIVES  = 3;
    localparam int READY_FRAMES = 4;
    localparam int DEATH_FRAMES = 3;
    localparam int END_FRAMES   = 5;
    localparam int BLINK_SHIFT  = 1;
    localparam logic [7:0] KEY  = 8'h2C;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       vsync;
    logic [7:0] keycode;
    logic       collide;
    logic       all_eaten;
    logic [2:0] game_state;
    logic       run_en;
    logic       pos_reset;
    logic       score_clear;
    logic [1:0] lives;
    logic       blink;
    logic       frame_stb;

    int n_cmp = 0;
    int n_bad = 0;

    int vs_mode   = 0;
    int vs_period = 40;
    int vs_ph     = 0;

    game_sequencer #(
        .START_LIVES (START_LIVES),
        .READY_FRAMES(READY_FRAMES),
        .DEATH_FRAMES(DEATH_FRAMES),
        .END_FRAMES  (END_FRAMES),
        .START_KEY   (KEY),
        .BLINK_SHIFT (BLINK_SHIFT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .vsync      (vsync),
        .keycode    (keycode),
        .collide    (collide),
        .all_eaten  (all_eaten),
        .game_state (game_state),
        .run_en     (run_en),
        .pos_reset  (pos_reset),
        .score_clear(score_clear),
        .lives      (lives),
        .blink      (blink),
        .frame_stb  (frame_stb)
    );

    initial forever #5 Clk = ~Clk;

    // vsync source: periodic (low 4 cycles per period), stuck high, or random toggles
    initial begin
        vsync = 1'b1;
        forever begin
            @(negedge Clk);
            case (vs_mode)
                0: begin
                    vs_ph = (vs_ph + 1) % vs_period;
                    vsync = (vs_ph >= 4);
                end
                1: vsync = 1'b1;
                default: if ($urandom_range(0, 5) == 0) vsync = ~vsync;
            endcase
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase, lives, strobes still needed to leave a timed phase, strobes since entry
    int m_phase   = 0;
    int m_lives   = 0;
    int m_left    = 0;
    int m_strobes = 0;
    bit m_done    = 0;
    bit m_pr      = 0;
    bit m_sc      = 0;
    bit m_stb     = 0;
    bit vs_hist[3] = '{1'b1, 1'b1, 1'b1};

    function automatic int frames_for(input int ph);
        case (ph)
            1:       return READY_FRAMES;
            3:       return DEATH_FRAMES;
            4, 5:    return END_FRAMES;
            default: return 0;
        endcase
    endfunction

    always @(posedge Clk) begin
        bit cur_stb;
        bit ex;
        bit start;
        int nxt;
        if (Reset) begin
            m_phase = 0; m_lives = 0; m_left = 0; m_strobes = 0;
            m_done = 0; m_pr = 0; m_sc = 0; m_stb = 0;
            vs_hist = '{1'b1, 1'b1, 1'b1};
        end else begin
            cur_stb = m_stb;
            // strobe appears three edges after the first low vsync sample
            m_stb = vs_hist[2] && !vs_hist[1];
            vs_hist[2] = vs_hist[1];
            vs_hist[1] = vs_hist[0];
            vs_hist[0] = vsync;
            start = (keycode == KEY);
            ex = cur_stb && (m_left <= 1);
            m_pr = 0;
            m_sc = 0;
            nxt = m_phase;
            case (m_phase)
                0: if (start) begin
                    nxt = 1; m_lives = START_LIVES; m_pr = 1; m_sc = 1;
                end
                1: if (ex) nxt = 2;
                2: if (collide) nxt = 3; else if (all_eaten) nxt = 4;
                3: if (ex) begin
                    if (m_lives == 1) nxt = 5;
                    else begin nxt = 1; m_pr = 1; end
                    m_lives = m_lives - 1;
                end
                4, 5: if (m_done && start) begin
                    nxt = 1; m_lives = START_LIVES; m_pr = 1; m_sc = 1;
                end
                default: nxt = 0;
            endcase
            if (nxt != m_phase) begin
                m_left = frames_for(nxt);
                m_strobes = 0;
                m_done = 0;
            end else if (cur_stb) begin
                m_strobes++;
                if (ex && (m_phase == 4 || m_phase == 5)) m_done = 1;
                else if (m_left > 1) m_left--;
            end
            m_phase = nxt;
        end
    end

    always @(negedge Clk) begin
        check("game_state",  int'(game_state),  m_phase);
        check("run_en",      int'(run_en),      (m_phase == 2) ? 1 : 0);
        check("pos_reset",   int'(pos_reset),   int'(m_pr));
        check("score_clear", int'(score_clear), int'(m_sc));
        check("lives",       int'(lives),       m_lives);
        check("blink",       int'(blink),       (m_strobes >> BLINK_SHIFT) & 1);
        check("frame_stb",   int'(frame_stb),   int'(m_stb));
    end

    task automatic wait_state(input int tgt, input int budget, input string nm,
                              output int nstb, output int gap);
        int c;
        int last;
        int prev;
        nstb = 0; c = 0; last = -1; prev = -1; gap = 0;
        while (int'(game_state) != tgt && c < budget) begin
            if (frame_stb) begin
                nstb++; prev = last; last = c;
            end
            @(negedge Clk);
            c++;
        end
        if (prev >= 0) gap = last - prev;
        if (int'(game_state) != tgt) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timed out in state %0d waiting for %0d", nm, game_state, tgt);
        end
    endtask

    task automatic wait_stb(input int budget);
        int c;
        c = 0;
        while (!frame_stb && c < budget) begin
            @(negedge Clk);
            c++;
        end
        if (!frame_stb) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_stb: no frame strobe within %0d cycles", budget);
        end
    endtask

    initial begin
        int nstb;
        int gap;
        int n;
        int c;
        int r;
        Reset = 1'b1; keycode = 8'h00; collide = 1'b0; all_eaten = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_state", int'(game_state), 0);
        check("rst_lives", int'(lives), 0);
        check("rst_run_en", int'(run_en), 0);
        check("rst_pos_reset", int'(pos_reset), 0);
        check("rst_blink", int'(blink), 0);
        Reset = 1'b0;

        // new game, timed away from a strobe
        wait_stb(100);
        repeat (5) @(negedge Clk);
        keycode = KEY;
        @(negedge Clk);
        keycode = 8'h00;
        check("start_state", int'(game_state), 1);
        check("start_lives", int'(lives), 3);
        check("start_score_clear", int'(score_clear), 1);
        check("start_pos_reset", int'(pos_reset), 1);
        @(negedge Clk);
        check("start_sc_once", int'(score_clear), 0);
        check("start_pr_once", int'(pos_reset), 0);
        wait_state(2, 400, "ready_to_play", nstb, gap);
        check("ready_strobes", nstb, 4);
        check("stb_spacing", gap, 40);
        check("play_run_en", int'(run_en), 1);

        // death with lives left
        collide = 1'b1;
        @(negedge Clk);
        collide = 1'b0;
        check("die_state", int'(game_state), 3);
        check("die_run_en", int'(run_en), 0);
        wait_state(1, 400, "dying_to_ready", nstb, gap);
        check("die_lives", int'(lives), 2);
        check("die_pos_reset", int'(pos_reset), 1);

        // collide beats all_eaten
        wait_state(2, 400, "ready_to_play2", nstb, gap);
        collide = 1'b1; all_eaten = 1'b1;
        @(negedge Clk);
        collide = 1'b0; all_eaten = 1'b0;
        check("prio_state", int'(game_state), 3);
        wait_state(1, 400, "dying_to_ready2", nstb, gap);
        check("prio_lives", int'(lives), 1);

        // last life, key held through GAMEOVER
        wait_state(2, 400, "ready_to_play3", nstb, gap);
        collide = 1'b1;
        @(negedge Clk);
        collide = 1'b0;
        wait_state(5, 400, "dying_to_over", nstb, gap);
        check("over_lives", int'(lives), 0);
        keycode = KEY;
        wait_state(1, 600, "over_to_ready", nstb, gap);
        check("over_strobes", nstb, END_FRAMES);
        check("over_restart_lives", int'(lives), 3);
        keycode = 8'h00;

        // win, hold after expiry, then restart
        wait_state(2, 400, "ready_to_play4", nstb, gap);
        all_eaten = 1'b1;
        @(negedge Clk);
        all_eaten = 1'b0;
        check("win_state", int'(game_state), 4);
        repeat (END_FRAMES * 40 + 80) @(negedge Clk);
        check("win_hold", int'(game_state), 4);
        keycode = KEY;
        @(negedge Clk);
        keycode = 8'h00;
        check("win_restart", int'(game_state), 1);
        check("win_score_clear", int'(score_clear), 1);

        // reset lands on the DYING expiry edge
        wait_state(2, 400, "ready_to_play5", nstb, gap);
        collide = 1'b1;
        n = 0; c = 0;
        while (n < DEATH_FRAMES && c < 600) begin
            @(negedge Clk);
            collide = 1'b0;
            c++;
            if (frame_stb) n++;
        end
        check("dying_strobes", n, DEATH_FRAMES);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rst_dying_state", int'(game_state), 0);
        check("rst_dying_lives", int'(lives), 0);
        check("rst_dying_pos_reset", int'(pos_reset), 0);

        // stuck vsync in READY
        repeat (3) @(negedge Clk);
        keycode = KEY;
        @(negedge Clk);
        keycode = 8'h00;
        vs_mode = 1;
        repeat (5) @(negedge Clk);
        n = 0;
        repeat (1000) begin
            @(negedge Clk);
            if (frame_stb) n++;
        end
        check("stuck_strobes", n, 0);
        check("stuck_state", int'(game_state), 1);

        // randomised play
        vs_mode = 0;
        vs_period = 12;
        for (int i = 0; i < 20000; i++) begin
            @(negedge Clk);
            if (i == 10000) vs_mode = 2;
            Reset = ($urandom_range(0, 1499) == 0);
            collide = ($urandom_range(0, 199) == 0);
            all_eaten = ($urandom_range(0, 299) == 0);
            r = int'($urandom_range(0, 99));
            keycode = (r < 4) ? KEY : ((r < 12) ? 8'($urandom) : 8'h00);
        end
        Reset = 1'b0; collide = 1'b0; all_eaten = 1'b0; keycode = 8'h00;
        repeat (4) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
